// File: rtl/arith_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : arith_unit_arbiter
//  Description : Shares one start/done arithmetic unit between N_REQ
//                requesters. Grants one requester at a time, latches its
//                operands, pulses u_start, waits for u_done and returns the
//                result with a one-cycle per-requester rsp_valid pulse.
//                Optional macro ARB_FIXED_PRIO_EN selects fixed priority
//                (lowest index wins); default is round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int SIZE  = 448,
  parameter int RES_W = 2 * SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*SIZE-1:0]   a_in,
  input  logic [N_REQ*SIZE-1:0]   b_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]        rsp_result,
  output logic                    busy,
  output logic                    u_start,
  output logic [SIZE-1:0]         u_a,
  output logic [SIZE-1:0]         u_b,
  input  logic [RES_W-1:0]        u_result,
  input  logic                    u_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] cur;         // requester currently being served
  logic             wait_first;  // high during the first WAIT cycle
  logic [IDX_W-1:0] win;         // arbitration winner among current requests
  logic             any_req;

  assign any_req = |req;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest set request index wins.
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) win = IDX_W'(k);
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;      // first index to consider next time
  int               rr_idx;
  logic             found;

  // Round-robin: first set request scanning from rr_ptr upward, wrapping.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[rr_idx]) begin
        found = 1'b1;
        win   = IDX_W'(rr_idx);
      end
    end
  end
`endif

  // Service sequencer: grant, issue to the unit, wait for done, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      wait_first <= 1'b0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
      u_start    <= 1'b0;
      u_a        <= '0;
      u_b        <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // Operands are captured here so later changes by the requester
          // cannot disturb the operation in flight.
          if (any_req) begin
            cur     <= win;
            gnt     <= ONE_HOT0 << win;
            u_a     <= a_in[int'(win) * SIZE +: SIZE];
            u_b     <= b_in[int'(win) * SIZE +: SIZE];
            u_start <= 1'b1;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          u_start    <= 1'b0;
          wait_first <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // The first WAIT cycle masks a done left over from the last op.
          wait_first <= 1'b0;
          if (!wait_first && u_done) begin
            rsp_result <= u_result;
            rsp_valid  <= gnt;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid <= '0;
          gnt       <= '0;
          busy      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr    <= (cur == LAST_IDX) ? '0 : cur + 1'b1;
`endif
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arith_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_unit_arbiter
//  Description : Scoreboard bench for arith_unit_arbiter with a behavioural
//                multiplier model and a transaction-level arbitration model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit_arbiter;

  localparam int N  = 4;
  localparam int SZ = 64;
  localparam int RW = 2 * SZ;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*SZ-1:0] a_in = '0;
  logic [N*SZ-1:0] b_in = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [RW-1:0]   rsp_result;
  logic            busy;
  logic            u_start;
  logic [SZ-1:0]   u_a;
  logic [SZ-1:0]   u_b;
  logic [RW-1:0]   u_result = '0;
  logic            u_done = 1'b0;

  arith_unit_arbiter #(.N_REQ(N), .SIZE(SZ), .RES_W(RW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy),
    .u_start(u_start), .u_a(u_a), .u_b(u_b), .u_result(u_result), .u_done(u_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            w;
    logic [SZ-1:0] a;
    logic [SZ-1:0] b;
    logic [RW-1:0] prod;
    int            k;   // cycle in which u_start must be high
    int            m;   // cycle in which rsp_valid must be high
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rr = 0;
  bit   m_busy = 1'b0;
  int   free_edge = 0;
  bit   stale = 1'b0;
  int   fixed_lat = 0;
  int   cnt = 0;
  bit   u_active = 1'b0;
  logic [SZ-1:0] ua_l = '0;
  logic [SZ-1:0] ub_l = '0;
  int   n_rsp = 0;
  int   n_start = 0;
  int   glog[$];

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  // Arbitration rule stated directly: who wins among the given requests.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i + 0 * ptr;
`else
    for (int i = 0; i < N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
`endif
    return -1;
  endfunction

  function automatic logic [SZ-1:0] rnd();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    return {$urandom, $urandom};
  endfunction

  // Reference model: a free arbiter with pending requests starts a service.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        sb_q.delete();
        m_busy    = 1'b0;
        rr        = 0;
        free_edge = 0;
      end else if (!m_busy && cyc >= free_edge && req != '0) begin
        exp_t e;
        int   w;
        w      = pick(req, rr);
        e.w    = w;
        e.a    = a_in[w * SZ +: SZ];
        e.b    = b_in[w * SZ +: SZ];
        e.prod = RW'(e.a) * RW'(e.b);
        e.k    = cyc;
        e.m    = -1;
        sb_q.push_back(e);
        m_busy = 1'b1;
      end
    end
  end

  // Multiplier model with start/done handshake; also fixes response timing.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        u_done   = 1'b0;
        u_active = 1'b0;
        cnt      = 0;
      end else begin
        if (u_active) begin
          cnt--;
          if (cnt == 0) begin
            u_done   = 1'b1;
            u_result = RW'(ua_l) * RW'(ub_l);
            u_active = 1'b0;
            if (sb_q.size() > 0) begin
              sb_q[0].m = cyc + 1;
              rr = (sb_q[0].w + 1) % N;
            end
            free_edge = cyc + 3;
            m_busy    = 1'b0;
          end
        end else if (!stale && u_done) begin
          u_done = 1'b0;
        end
        if (u_start) begin
          u_active = 1'b1;
          ua_l     = u_a;
          ub_l     = u_b;
          if (stale)              cnt = 2;
          else if (fixed_lat > 0) cnt = fixed_lat + 1;
          else                    cnt = $urandom_range(1, 4) + 1;
        end
      end
    end
  end

  // Monitor: compares issues and responses against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (u_start) begin
        n_start++;
        glog.push_back(int'(gnt));
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: u_start with no expected service, gnt=%b", gnt);
        end else if (cyc != sb_q[0].k || gnt != onehot(sb_q[0].w) ||
                     u_a != sb_q[0].a || u_b != sb_q[0].b) begin
          errors++;
          $display("FAIL issue: cyc=%0d gnt=%b u_a=%h u_b=%h expected cyc=%0d gnt=%b u_a=%h u_b=%h",
                   cyc, gnt, u_a, u_b, sb_q[0].k, onehot(sb_q[0].w), sb_q[0].a, sb_q[0].b);
        end
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with nothing expected", rsp_valid);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (rsp_valid != onehot(e.w) || rsp_result != e.prod || cyc != e.m) begin
            errors++;
            $display("FAIL rsp: cyc=%0d rsp_valid=%b result=%h expected cyc=%0d rsp_valid=%b result=%h",
                     cyc, rsp_valid, rsp_result, e.m, onehot(e.w), e.prod);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int i;
    i = 0;
    while (n_rsp < target && i < budget) begin
      step();
      i++;
    end
    checks++;
    if (n_rsp < target) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", n_rsp, target);
    end
  endtask

  task automatic wait_start(input int budget);
    int i;
    i = 0;
    while (!u_start && i < budget) begin
      step();
      i++;
    end
    checks++;
    if (!u_start) begin
      errors++;
      $display("FAIL start_timeout: u_start=0 expected 1");
    end
  endtask

  task automatic set_op(input int i, input logic [SZ-1:0] a, input logic [SZ-1:0] b);
    a_in[i * SZ +: SZ] = a;
    b_in[i * SZ +: SZ] = b;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    step();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int starts0;
    int exp_g[5];
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{2, 2, 2, 2, 2};
`else
    exp_g = '{1, 2, 4, 8, 1};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", RW'(gnt), '0);
    check("rst_rsp_valid", RW'(rsp_valid), '0);
    check("rst_busy", RW'(busy), '0);
    check("rst_u_start", RW'(u_start), '0);
    check("rst_u_a", RW'(u_a), '0);
    check("rst_rsp_result", rsp_result, '0);
    #1 rst = 1'b0;
    step();

    // Single request: 3 * 5
    fixed_lat = 4;
    set_op(0, 64'd3, 64'd5);
    base    = n_rsp;
    starts0 = n_start;
    req     = 4'b0001;
    wait_rsp(base + 1, 60);
    req = '0;
    check("single_result", rsp_result, RW'(15));
    check("single_u_a", RW'(u_a), RW'(3));
    check("single_u_b", RW'(u_b), RW'(5));
    repeat (4) step();
    check("single_one_start", RW'(n_start - starts0), RW'(1));

    // Contention with all (or two) requesters held high
    reset_pulse();
    fixed_lat = 0;
    for (int i = 0; i < N; i++) set_op(i, rnd(), rnd());
    glog.delete();
    base = n_rsp;
`ifdef ARB_FIXED_PRIO_EN
    req = 4'b0110;
`else
    req = 4'b1111;
`endif
    wait_rsp(base + 5, 200);
    req = '0;
    repeat (6) step();
    check("contend_count", RW'(glog.size()), RW'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < glog.size()) check($sformatf("contend_gnt%0d", i), RW'(glog[i]), RW'(exp_g[i]));
    end

    // Stale done held high across back-to-back operations
    stale = 1'b1;
    set_op(0, 64'd11, 64'd13);
    base = n_rsp;
    req  = 4'b0001;
    wait_rsp(base + 1, 60);
    set_op(0, 64'd17, 64'd19);
    wait_rsp(base + 2, 60);
    req = '0;
    check("stale_result", rsp_result, RW'(17 * 19));
    stale = 1'b0;
    repeat (4) step();

    // Reset while waiting for the unit
    fixed_lat = 6;
    set_op(2, rnd(), rnd());
    req = 4'b0100;
    wait_start(20);
    step();
    rst = 1'b1;
    #1;
    check("midrst_gnt", RW'(gnt), '0);
    check("midrst_u_start", RW'(u_start), '0);
    check("midrst_rsp_valid", RW'(rsp_valid), '0);
    check("midrst_busy", RW'(busy), '0);
    req  = '0;
    base = n_rsp;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) step();
    check("midrst_no_rsp", RW'(n_rsp), RW'(base));

    // Operands changed after grant
    fixed_lat = 3;
    set_op(1, 64'd7, 64'd9);
    base = n_rsp;
    req  = 4'b0010;
    wait_start(20);
    set_op(1, 64'd100, 64'd200);
    step();
    check("opchg_u_a", RW'(u_a), RW'(7));
    wait_rsp(base + 1, 60);
    req = '0;
    check("opchg_result", rsp_result, RW'(63));
    check("opchg_u_b", RW'(u_b), RW'(9));
    repeat (3) step();

    // Randomized traffic
    fixed_lat = 0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_op(i, rnd(), rnd());
            req[i] = 1'b1;
          end
        end else if (rsp_valid[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else set_op(i, rnd(), rnd());
        end else if (gnt[i] && $urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else set_op(i, rnd(), rnd());
        end
      end
      step();
    end
    req = '0;
    for (int c = 0; c < 100 && (sb_q.size() != 0 || m_busy); c++) step();
    check("drain_empty", RW'(sb_q.size()), '0);
    repeat (3) step();
    check("final_busy", RW'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
